// File: rtl/i2c_slave_core.sv
// I2C target: START/STOP detection, 7-bit address match, byte receive and transmit.
// Define I2C_SLAVE_STRETCH_EN to hold SCL low on reads until tx_valid is asserted.
module i2c_slave_core #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  inout  wire        sda,
  inout  wire        scl,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_load,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rw,
  output logic       addr_match,
  output logic       nack_rcvd,
  output logic       start_det,
  output logic       stop_det,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    RX       = 3'd3,
    RX_ACK   = 3'd4,
    TX       = 3'd5,
    TX_ACK   = 3'd6,
    IGNORE   = 3'd7
  } state_t;

  state_t state_r, state_n;

  logic [SYNC_STAGES-1:0] sda_sync_r, scl_sync_r;
  logic sda_prev_r, scl_prev_r, sda_s, scl_s;
  logic start_s, stop_s, scl_rise_s, scl_fall_s;
  logic addr_hit_s, tx_enter_s, load_now_s, stretch_req_s;

  logic [2:0] bit_cnt_r, bit_cnt_n;
  logic [7:0] shift_r, shift_n, rx_data_r, rx_data_n;
  logic ack_pend_r, ack_pend_n, sda_oe_r, sda_oe_n, rw_r, rw_n;
  logic busy_r, busy_n, stretch_r, stretch_n;
  logic rx_valid_r, rx_valid_n, tx_load_r, tx_load_n, addr_match_r, addr_match_n;
  logic nack_r, nack_n, start_r, start_n, stop_r, stop_n;

  // Pin synchronizers plus one history stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_sync_r <= {SYNC_STAGES{1'b1}};
      scl_sync_r <= {SYNC_STAGES{1'b1}};
      sda_prev_r <= 1'b1;
      scl_prev_r <= 1'b1;
    end else begin
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda};
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl};
      sda_prev_r <= sda_s;
      scl_prev_r <= scl_s;
    end
  end

  assign sda_s      = sda_sync_r[SYNC_STAGES-1];
  assign scl_s      = scl_sync_r[SYNC_STAGES-1];
  assign start_s    = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
  assign stop_s     = scl_s & scl_prev_r & ~sda_prev_r & sda_s;
  assign scl_rise_s = scl_s & ~scl_prev_r;
  assign scl_fall_s = ~scl_s & scl_prev_r;
  // shift_r[6:0] holds the seven address bits when the R/W bit arrives
  assign addr_hit_s = (shift_r[6:0] == SLAVE_ADDR);
  assign tx_enter_s = scl_fall_s & (((state_r == ADDR_ACK) & rw_r) |
                                    ((state_r == TX_ACK) & ack_pend_r));
  assign sda        = sda_oe_r ? 1'b0 : 1'bz;

`ifdef I2C_SLAVE_STRETCH_EN
  logic scl_oe_r;

  // SCL is held through the load cycle and released one clk after it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_oe_r <= 1'b0;
    end else begin
      scl_oe_r <= stretch_n | (stretch_r & ~start_s & ~stop_s);
    end
  end

  assign scl           = scl_oe_r ? 1'b0 : 1'bz;
  assign load_now_s    = (tx_enter_s | stretch_r) & tx_valid;
  assign stretch_req_s = tx_enter_s & ~tx_valid;
`else
  logic unused_tx_valid_s;
  assign unused_tx_valid_s = tx_valid;
  assign scl               = 1'bz;
  assign load_now_s        = tx_enter_s;
  assign stretch_req_s     = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // FSM next-state logic; bus START/STOP override everything
  always_comb begin
    state_n = state_r;
    if (start_s) begin
      state_n = ADDR;
    end else if (stop_s) begin
      state_n = IDLE;
    end else begin
      case (state_r)
        IDLE:     state_n = IDLE;
        ADDR: begin
          if (scl_rise_s && (bit_cnt_r == 3'd0) && !addr_hit_s) state_n = IGNORE;
          else if (scl_fall_s && ack_pend_r)                    state_n = ADDR_ACK;
          else                                                  state_n = ADDR;
        end
        ADDR_ACK: state_n = scl_fall_s ? (rw_r ? TX : RX) : ADDR_ACK;
        RX:       state_n = (scl_fall_s && ack_pend_r) ? RX_ACK : RX;
        RX_ACK:   state_n = scl_fall_s ? RX : RX_ACK;
        TX:       state_n = (scl_fall_s && !stretch_r && (bit_cnt_r == 3'd0)) ? TX_ACK : TX;
        TX_ACK: begin
          if (scl_rise_s && sda_s)            state_n = IGNORE;
          else if (scl_fall_s && ack_pend_r)  state_n = TX;
          else                                state_n = TX_ACK;
        end
        IGNORE:   state_n = IGNORE;
        default:  state_n = IDLE;
      endcase
    end
  end

  // FSM output and datapath next values
  always_comb begin
    bit_cnt_n    = bit_cnt_r;
    shift_n      = shift_r;
    rx_data_n    = rx_data_r;
    ack_pend_n   = ack_pend_r;
    sda_oe_n     = sda_oe_r;
    rw_n         = rw_r;
    busy_n       = busy_r;
    stretch_n    = stretch_r;
    rx_valid_n   = 1'b0;
    tx_load_n    = 1'b0;
    addr_match_n = 1'b0;
    nack_n       = 1'b0;
    start_n      = 1'b0;
    stop_n       = 1'b0;
    if (start_s) begin
      start_n    = 1'b1;
      bit_cnt_n  = 3'd7;
      ack_pend_n = 1'b0;
      sda_oe_n   = 1'b0;
      stretch_n  = 1'b0;
    end else if (stop_s) begin
      stop_n     = 1'b1;
      busy_n     = 1'b0;
      ack_pend_n = 1'b0;
      sda_oe_n   = 1'b0;
      stretch_n  = 1'b0;
    end else begin
      case (state_r)
        ADDR, RX: begin
          if (scl_rise_s) begin
            shift_n   = {shift_r[6:0], sda_s};
            bit_cnt_n = bit_cnt_r - 3'd1;
            if (bit_cnt_r != 3'd0) begin
              ack_pend_n = 1'b0;
            end else if (state_r == RX) begin
              rx_data_n  = {shift_r[6:0], sda_s};
              rx_valid_n = 1'b1;
              ack_pend_n = 1'b1;
            end else if (addr_hit_s) begin
              rw_n       = sda_s;
              ack_pend_n = 1'b1;
            end else begin
              busy_n = 1'b0;
            end
          end else if (scl_fall_s && ack_pend_r) begin
            sda_oe_n     = 1'b1;
            ack_pend_n   = 1'b0;
            addr_match_n = (state_r == ADDR);
            busy_n       = busy_r | (state_r == ADDR);
          end else begin
            ack_pend_n = ack_pend_r;
          end
        end
        ADDR_ACK, RX_ACK: sda_oe_n = scl_fall_s ? 1'b0 : sda_oe_r;
        TX: begin
          if (scl_fall_s && !stretch_r) begin
            if (bit_cnt_r == 3'd0) begin
              sda_oe_n = 1'b0;
            end else begin
              sda_oe_n  = ~shift_r[6];
              shift_n   = {shift_r[6:0], shift_r[7]};
              bit_cnt_n = bit_cnt_r - 3'd1;
            end
          end else begin
            sda_oe_n = sda_oe_r;
          end
        end
        TX_ACK: begin
          if (scl_rise_s) begin
            nack_n     = sda_s;
            ack_pend_n = ~sda_s;
          end else if (scl_fall_s) begin
            ack_pend_n = 1'b0;
          end else begin
            ack_pend_n = ack_pend_r;
          end
        end
        IDLE, IGNORE: sda_oe_n = 1'b0;
        default:      sda_oe_n = 1'b0;
      endcase
      if (load_now_s) begin
        shift_n   = tx_data;
        tx_load_n = 1'b1;
        sda_oe_n  = ~tx_data[7];
        bit_cnt_n = 3'd7;
        stretch_n = 1'b0;
      end else if (stretch_req_s) begin
        stretch_n = 1'b1;
        sda_oe_n  = 1'b0;
      end else begin
        stretch_n = stretch_n;
      end
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r    <= 3'd7;
      shift_r      <= 8'h00;
      rx_data_r    <= 8'h00;
      ack_pend_r   <= 1'b0;
      sda_oe_r     <= 1'b0;
      rw_r         <= 1'b0;
      busy_r       <= 1'b0;
      stretch_r    <= 1'b0;
      rx_valid_r   <= 1'b0;
      tx_load_r    <= 1'b0;
      addr_match_r <= 1'b0;
      nack_r       <= 1'b0;
      start_r      <= 1'b0;
      stop_r       <= 1'b0;
    end else begin
      bit_cnt_r    <= bit_cnt_n;
      shift_r      <= shift_n;
      rx_data_r    <= rx_data_n;
      ack_pend_r   <= ack_pend_n;
      sda_oe_r     <= sda_oe_n;
      rw_r         <= rw_n;
      busy_r       <= busy_n;
      stretch_r    <= stretch_n;
      rx_valid_r   <= rx_valid_n;
      tx_load_r    <= tx_load_n;
      addr_match_r <= addr_match_n;
      nack_r       <= nack_n;
      start_r      <= start_n;
      stop_r       <= stop_n;
    end
  end

  assign tx_load    = tx_load_r;
  assign rx_data    = rx_data_r;
  assign rx_valid   = rx_valid_r;
  assign rw         = rw_r;
  assign addr_match = addr_match_r;
  assign nack_rcvd  = nack_r;
  assign start_det  = start_r;
  assign stop_det   = stop_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_i2c_slave_core.sv
// Directed bench for i2c_slave_core: a bit-banged open-drain master drives the bus.
// Define I2C_SLAVE_STRETCH_EN to add the clock-stretch scenario.
module tb_i2c_slave_core;
  localparam int Q = 25;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_load, rx_valid, rw, addr_match, nack_rcvd, start_det, stop_det, busy;
  logic [7:0] rx_data;
  logic       m_sda_low, m_scl_low;
  wire        sda, scl;

  assign sda = m_sda_low ? 1'b0 : 1'bz;
  assign scl = m_scl_low ? 1'b0 : 1'bz;
  pullup (sda);
  pullup (scl);

  int errors = 0, checks = 0;
  int n_start = 0, n_stop = 0, n_addr = 0, n_rxv = 0, n_txl = 0, n_nack = 0;
  int cur_low = 0, max_low = 0;
  logic [7:0] rx_log [0:15];

  always #5 clk = ~clk;

  i2c_slave_core dut (
    .clk(clk), .rst_n(rst_n), .sda(sda), .scl(scl),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_load(tx_load),
    .rx_data(rx_data), .rx_valid(rx_valid), .rw(rw), .addr_match(addr_match),
    .nack_rcvd(nack_rcvd), .start_det(start_det), .stop_det(stop_det), .busy(busy)
  );

  // Pulse counters, received-byte log and SCL low-time tracker
  always @(negedge clk) begin
    if (start_det)  n_start++;
    if (stop_det)   n_stop++;
    if (addr_match) n_addr++;
    if (tx_load)    n_txl++;
    if (nack_rcvd)  n_nack++;
    if (rx_valid) begin
      if (n_rxv < 16) rx_log[n_rxv] = rx_data;
      n_rxv++;
    end
    if (scl === 1'b0) begin
      cur_low++;
      if (cur_low > max_low) max_low = cur_low;
    end else begin
      cur_low = 0;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_release;
    int w;
    m_scl_low = 1'b0;
    w = 0;
    while (scl !== 1'b1 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (scl !== 1'b1) begin
      errors++;
      $display("FAIL scl_release: scl=%b after %0d clk, required 1", scl, w);
    end
  endtask

  task automatic bus_start;
    m_sda_low = 1'b0; wait_clks(Q);
    scl_release;      wait_clks(Q);
    m_sda_low = 1'b1; wait_clks(Q);
    m_scl_low = 1'b1; wait_clks(Q);
  endtask

  task automatic bus_stop;
    m_sda_low = 1'b1; wait_clks(Q);
    scl_release;      wait_clks(Q);
    m_sda_low = 1'b0; wait_clks(2 * Q);
  endtask

  task automatic write_bit(input logic b);
    wait_clks(Q);
    m_sda_low = ~b;
    wait_clks(Q);
    scl_release;
    wait_clks(2 * Q);
    m_scl_low = 1'b1;
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0;
    wait_clks(2 * Q);
    scl_release;
    wait_clks(Q);
    b = sda;
    wait_clks(Q);
    m_scl_low = 1'b1;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; m_sda_low = 1'b0; m_scl_low = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b1;
    wait_clks(5);
    rst_n = 1'b1;
    wait_clks(5);
    checks++;
    if ({tx_load, rx_valid, rw, addr_match, nack_rcvd, start_det, stop_det, busy} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 00000000",
               {tx_load, rx_valid, rw, addr_match, nack_rcvd, start_det, stop_det, busy});
    end
    checks++;
    if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h required 00", rx_data); end
    checks++;
    if ({sda, scl} !== 2'b11) begin errors++; $display("FAIL reset_bus: got %b required 11", {sda, scl}); end
  endtask

  task automatic test_write;
    logic ack;
    int b_addr, b_rxv, b_stop;
    b_addr = n_addr; b_rxv = n_rxv; b_stop = n_stop;
    bus_start;
    write_byte(8'hA0, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL write_addr_ack: got %b required 0", ack); end
    checks++;
    if ({busy, rw} !== 2'b10) begin errors++; $display("FAIL write_busy_rw: got %b required 10", {busy, rw}); end
    write_byte(8'h3C, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL write_data1_ack: got %b required 0", ack); end
    write_byte(8'h5A, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL write_data2_ack: got %b required 0", ack); end
    bus_stop;
    checks++;
    if (n_addr - b_addr != 1) begin errors++; $display("FAIL write_addr_match: got %0d required 1", n_addr - b_addr); end
    checks++;
    if (n_rxv - b_rxv != 2) begin errors++; $display("FAIL write_rx_valid: got %0d required 2", n_rxv - b_rxv); end
    checks++;
    if (rx_log[b_rxv] !== 8'h3C || rx_log[b_rxv + 1] !== 8'h5A) begin
      errors++;
      $display("FAIL write_rx_data: got %h %h required 3c 5a", rx_log[b_rxv], rx_log[b_rxv + 1]);
    end
    checks++;
    if (n_stop - b_stop != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL write_stop: got stops=%0d busy=%b required 1 0", n_stop - b_stop, busy);
    end
  endtask

  task automatic test_addr_miss;
    logic ack;
    int b_addr, b_rxv, b_stop;
    b_addr = n_addr; b_rxv = n_rxv; b_stop = n_stop;
    bus_start;
    write_byte(8'hA2, ack);
    checks++;
    if (ack !== 1'b1) begin errors++; $display("FAIL miss_addr_ack: got %b required 1", ack); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL miss_busy: got %b required 0", busy); end
    write_byte(8'h11, ack);
    checks++;
    if (ack !== 1'b1) begin errors++; $display("FAIL miss_data_ack: got %b required 1", ack); end
    bus_stop;
    checks++;
    if (n_rxv != b_rxv || n_addr != b_addr) begin
      errors++;
      $display("FAIL miss_pulses: got rxv=%0d addr=%0d required 0 0", n_rxv - b_rxv, n_addr - b_addr);
    end
    checks++;
    if (n_stop - b_stop != 1) begin errors++; $display("FAIL miss_stop: got %0d required 1", n_stop - b_stop); end
  endtask

  task automatic test_read;
    logic ack;
    logic [7:0] d0, d1;
    int b_txl, b_nack;
    b_txl = n_txl; b_nack = n_nack;
    tx_data = 8'hC3;
    bus_start;
    write_byte(8'hA1, ack);
    checks++;
    if ({ack, rw} !== 2'b01) begin errors++; $display("FAIL read_addr_ack_rw: got %b required 01", {ack, rw}); end
    read_byte(d0);
    tx_data = 8'h7E;
    write_bit(1'b0);
    read_byte(d1);
    write_bit(1'b1);
    wait_clks(Q);
    checks++;
    if (sda !== 1'b1) begin errors++; $display("FAIL read_sda_released: got %b required 1", sda); end
    bus_stop;
    checks++;
    if (d0 !== 8'hC3 || d1 !== 8'h7E) begin errors++; $display("FAIL read_bytes: got %h %h required c3 7e", d0, d1); end
    checks++;
    if (n_txl - b_txl != 2) begin errors++; $display("FAIL read_tx_load: got %0d required 2", n_txl - b_txl); end
    checks++;
    if (n_nack - b_nack != 1) begin errors++; $display("FAIL read_nack: got %0d required 1", n_nack - b_nack); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL read_busy: got %b required 0", busy); end
  endtask

  task automatic test_repeated_start;
    logic ack;
    logic [7:0] d;
    int b_start, b_addr;
    b_start = n_start; b_addr = n_addr;
    bus_start;
    write_byte(8'hA0, ack);
    checks++;
    if ({ack, rw} !== 2'b00) begin errors++; $display("FAIL rs_first_ack_rw: got %b required 00", {ack, rw}); end
    write_byte(8'h01, ack);
    bus_start;
    write_byte(8'hA1, ack);
    checks++;
    if ({ack, rw} !== 2'b01) begin errors++; $display("FAIL rs_second_ack_rw: got %b required 01", {ack, rw}); end
    tx_data = 8'h96;
    read_byte(d);
    write_bit(1'b1);
    bus_stop;
    checks++;
    if (n_start - b_start != 2 || n_addr - b_addr != 2) begin
      errors++;
      $display("FAIL rs_counts: got start=%0d addr=%0d required 2 2", n_start - b_start, n_addr - b_addr);
    end
    checks++;
    if (rx_data !== 8'h01 || d !== 8'h96) begin
      errors++;
      $display("FAIL rs_data: got rx=%h rd=%h required 01 96", rx_data, d);
    end
  endtask

  task automatic test_reset_mid_read;
    logic ack, b;
    int b_start;
    tx_data = 8'h00;
    bus_start;
    write_byte(8'hA1, ack);
    for (int i = 0; i < 3; i++) read_bit(b);
    m_sda_low = 1'b0;
    wait_clks(2 * Q);
    scl_release;
    wait_clks(Q);
    checks++;
    if (sda !== 1'b0) begin errors++; $display("FAIL midrd_driving: got %b required 0", sda); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (sda !== 1'b1) begin errors++; $display("FAIL midrd_sda_release: got %b required 1", sda); end
    checks++;
    if ({busy, rw, rx_data} !== 10'h000) begin
      errors++;
      $display("FAIL midrd_outputs: got busy=%b rw=%b rx=%h required 0 0 00", busy, rw, rx_data);
    end
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(3);
    b_start = n_start;
    bus_start;
    write_byte(8'hA0, ack);
    checks++;
    if (ack !== 1'b0 || n_start - b_start != 1) begin
      errors++;
      $display("FAIL midrd_restart: got ack=%b starts=%0d required 0 1", ack, n_start - b_start);
    end
    bus_stop;
  endtask

`ifdef I2C_SLAVE_STRETCH_EN
  task automatic test_stretch;
    logic ack;
    logic [7:0] d;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    bus_start;
    write_byte(8'hA1, ack);
    max_low = 0;
    fork
      begin
        wait_clks(500);
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
      end
      read_byte(d);
    join
    write_bit(1'b1);
    bus_stop;
    checks++;
    if (max_low < 500) begin errors++; $display("FAIL stretch_low_time: got %0d required >=500", max_low); end
    checks++;
    if (d !== 8'hA5) begin errors++; $display("FAIL stretch_byte: got %h required a5", d); end
    checks++;
    if (scl !== 1'b1) begin errors++; $display("FAIL stretch_release: got %b required 1", scl); end
  endtask
`endif

  initial begin
    test_reset;
    test_write;
    test_addr_miss;
    test_read;
    test_repeated_start;
    test_reset_mid_read;
`ifdef I2C_SLAVE_STRETCH_EN
    test_stretch;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
